// File: rtl/execute_pipe.sv
// Registered execute stage: ALU, branch/jump resolution, link values and an iterative
// MULTU/DIVU unit with HI/LO. Define EXEC_OVF_EN to register ADD/SUB signed overflow on out_ovf.
`timescale 1ns/1ps
module execute_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned SA_W   = $clog2(DATA_W)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] in_s1,
  input  logic [DATA_W-1:0] in_s2,
  input  logic [15:0]       im,
  input  logic              use_im,
  input  logic              sign_x,
  input  logic [SA_W-1:0]   sa,
  input  logic [1:0]        br_type,
  input  logic              jp,
  input  logic              jr,
  input  logic              link,
  input  logic [25:0]       instr_idx,
  input  logic [PC_W-1:0]   pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_val,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_taken,
  output logic              out_ovf
);

  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [3:0] OpAdd = 4'd0, OpSub = 4'd1, OpAnd = 4'd2, OpOr = 4'd3, OpXor = 4'd4;
  localparam logic [3:0] OpNor = 4'd5, OpSlt = 4'd6, OpSltu = 4'd7, OpSll = 4'd8, OpSrl = 4'd9;
  localparam logic [3:0] OpSra = 4'd10, OpMultu = 4'd11, OpDivu = 4'd12, OpMfhi = 4'd13;
  localparam logic [3:0] OpMflo = 4'd14, OpLui = 4'd15;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e                state_q, state_d;
  logic [2*DATA_W-1:0]   work_q, work_d;
  logic [DATA_W-1:0]     opnd_q, hi_q, lo_q, out_val_q;
  logic [CntW-1:0]       cnt_q;
  logic [PC_W-1:0]       out_pc_q;
  logic                  out_valid_q, out_taken_q;

  logic                  accept, is_muldiv, busy, last;
  logic [DATA_W-1:0]     imm_ext, opb, sum, diff, alu_res;
  logic [PC_W-1:0]       pc4, br_tgt, jp_tgt, nxt_pc;
  logic                  br_taken, nxt_taken;
  logic [2*DATA_W:0]     sh;
  logic [DATA_W:0]       trial, madd;

  assign accept    = in_valid && in_ready;
  assign is_muldiv = (alu_op == OpMultu) || (alu_op == OpDivu);
  assign busy      = (state_q != StIdle);
  assign last      = busy && (cnt_q == CntW'(DATA_W - 1));

  always_comb begin
    imm_ext = sign_x ? DATA_W'($signed(im)) : DATA_W'(im);
    opb     = use_im ? imm_ext : in_s2;
    sum     = in_s1 + opb;
    diff    = in_s1 - opb;
    alu_res = '0;
    unique case (alu_op)
      OpAdd:   alu_res = sum;
      OpSub:   alu_res = diff;
      OpAnd:   alu_res = in_s1 & opb;
      OpOr:    alu_res = in_s1 | opb;
      OpXor:   alu_res = in_s1 ^ opb;
      OpNor:   alu_res = ~(in_s1 | opb);
      OpSlt:   alu_res = DATA_W'($signed(in_s1) < $signed(opb));
      OpSltu:  alu_res = DATA_W'(in_s1 < opb);
      OpSll:   alu_res = opb << sa;
      OpSrl:   alu_res = opb >> sa;
      OpSra:   alu_res = $signed(opb) >>> sa;
      OpMfhi:  alu_res = hi_q;
      OpMflo:  alu_res = lo_q;
      OpLui:   alu_res = DATA_W'({im, 16'h0000});
      default: alu_res = '0;
    endcase
    if (link) alu_res = DATA_W'(pc4);
  end

  always_comb begin
    pc4    = pc + PC_W'(4);
    br_tgt = pc4 + (PC_W'($signed(im)) << 2);
    jp_tgt = pc4;
    jp_tgt[27:0] = {instr_idx, 2'b00};
    unique case (br_type)
      2'd1:    br_taken = (in_s1 == in_s2);
      2'd2:    br_taken = (in_s1 != in_s2);
      2'd3:    br_taken = !in_s1[DATA_W-1] && (in_s1 != '0);
      default: br_taken = 1'b0;
    endcase
    nxt_taken = jr || jp || br_taken;
    if (jr)            nxt_pc = PC_W'(in_s1);
    else if (jp)       nxt_pc = jp_tgt;
    else if (br_taken) nxt_pc = br_tgt;
    else               nxt_pc = pc4;
  end

  // One shift-add (MUL) or restoring-subtract (DIV) step; both keep HI:LO layout in work_q.
  always_comb begin
    sh    = {work_q, 1'b0};
    trial = sh[2*DATA_W:DATA_W] - {1'b0, opnd_q};
    madd  = {1'b0, work_q[2*DATA_W-1:DATA_W]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    if (state_q == StMul)  work_d = {madd, work_q[DATA_W-1:1]};
    else if (!trial[DATA_W]) work_d = {trial[DATA_W-1:0], sh[DATA_W-1:1], 1'b1};
    else                   work_d = sh[2*DATA_W-1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && alu_op == OpMultu)     state_d = StMul;
        else if (accept && alu_op == OpDivu) state_d = StDiv;
      end
      StMul, StDiv: if (last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_comb begin
    in_ready = (state_q == StIdle) && (!out_valid_q || out_ready) && !flush;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      work_q      <= '0;
      opnd_q      <= '0;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      out_val_q   <= '0;
      out_pc_q    <= '0;
      out_valid_q <= 1'b0;
      out_taken_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      out_taken_q <= 1'b0;
      cnt_q       <= '0;
    end else if (accept) begin
      out_pc_q    <= nxt_pc;
      out_taken_q <= nxt_taken;
      out_valid_q <= !is_muldiv;
      if (is_muldiv) begin
        work_q <= {{DATA_W{1'b0}}, in_s1};
        opnd_q <= in_s2;
        cnt_q  <= '0;
      end else begin
        out_val_q <= alu_res;
      end
    end else begin
      if (out_ready) out_valid_q <= 1'b0;
      if (busy) begin
        work_q <= work_d;
        cnt_q  <= cnt_q + 1'b1;
        if (last) begin
          hi_q        <= work_d[2*DATA_W-1:DATA_W];
          lo_q        <= work_d[DATA_W-1:0];
          out_val_q   <= work_d[DATA_W-1:0];
          out_valid_q <= 1'b1;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_val   = out_val_q;
  assign out_pc    = out_pc_q;
  assign out_taken = out_taken_q;

`ifdef EXEC_OVF_EN
  logic ovf, ovf_q;
  always_comb begin
    ovf = 1'b0;
    if (!link && alu_op == OpAdd)
      ovf = (in_s1[DATA_W-1] == opb[DATA_W-1]) && (sum[DATA_W-1] != in_s1[DATA_W-1]);
    else if (!link && alu_op == OpSub)
      ovf = (in_s1[DATA_W-1] != opb[DATA_W-1]) && (diff[DATA_W-1] != in_s1[DATA_W-1]);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                     ovf_q <= 1'b0;
    else if (!flush && accept)        ovf_q <= ovf;
    else if (!flush && busy && last)  ovf_q <= 1'b0;
  end
  assign out_ovf = ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_execute_pipe.sv
// Scoreboard bench for execute_pipe: directed corner cases plus randomized traffic
// checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_execute_pipe;

  logic        clock = 1'b0, reset_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, out_taken, out_ovf;
  logic [3:0]  alu_op = '0;
  logic [31:0] in_s1 = '0, in_s2 = '0, pc = '0, out_val, out_pc;
  logic [15:0] im = '0;
  logic        use_im = 1'b0, sign_x = 1'b0, jp = 1'b0, jr = 1'b0, link = 1'b0;
  logic [4:0]  sa = '0;
  logic [1:0]  br_type = '0;
  logic [25:0] instr_idx = '0;

  typedef struct {
    logic [3:0] op; logic [31:0] s1, s2; logic [15:0] im; logic use_im, sign_x;
    logic [4:0] sa; logic [1:0] br; logic jp, jr, link; logic [25:0] idx; logic [31:0] pc;
  } req_t;
  typedef struct { logic [31:0] val, npc; logic taken, ovf; } exp_t;

  exp_t        sb[$];
  logic [31:0] hi_m = '0, lo_m = '0;
  int          checks = 0, failures = 0;
  bit          rnd_ready = 1'b0, ready_force = 1'b1;

  execute_pipe dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .in_s1(in_s1), .in_s2(in_s2), .im(im), .use_im(use_im), .sign_x(sign_x),
    .sa(sa), .br_type(br_type), .jp(jp), .jr(jr), .link(link), .instr_idx(instr_idx), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val), .out_pc(out_pc),
    .out_taken(out_taken), .out_ovf(out_ovf)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    #1;
    out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference model: plain arithmetic on the architectural rules; updates HI/LO on MULTU/DIVU.
  function automatic exp_t model(req_t r);
    exp_t e;
    logic [31:0] b, pc4;
    logic [63:0] p;
    longint s, lim;
    bit tk;
    lim = 64'sd2147483647;
    b = r.use_im ? (r.sign_x ? {{16{r.im[15]}}, r.im} : {16'h0, r.im}) : r.s2;
    e.ovf = 1'b0;
    case (r.op)
      4'd0: begin
        e.val = r.s1 + b;
        s = longint'($signed(r.s1)) + longint'($signed(b));
        e.ovf = (s > lim) || (s < -lim - 1);
      end
      4'd1: begin
        e.val = r.s1 - b;
        s = longint'($signed(r.s1)) - longint'($signed(b));
        e.ovf = (s > lim) || (s < -lim - 1);
      end
      4'd2: e.val = r.s1 & b;
      4'd3: e.val = r.s1 | b;
      4'd4: e.val = r.s1 ^ b;
      4'd5: e.val = ~(r.s1 | b);
      4'd6: e.val = ($signed(r.s1) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7: e.val = (r.s1 < b) ? 32'd1 : 32'd0;
      4'd8: e.val = b << r.sa;
      4'd9: e.val = b >> r.sa;
      4'd10: e.val = $signed(b) >>> r.sa;
      4'd11: begin
        p = {32'h0, r.s1} * {32'h0, r.s2};
        hi_m = p[63:32]; lo_m = p[31:0]; e.val = lo_m;
      end
      4'd12: begin
        if (r.s2 == 0) begin lo_m = 32'hFFFF_FFFF; hi_m = r.s1; end
        else begin lo_m = r.s1 / r.s2; hi_m = r.s1 % r.s2; end
        e.val = lo_m;
      end
      4'd13: e.val = hi_m;
      4'd14: e.val = lo_m;
      default: e.val = {r.im, 16'h0};
    endcase
    pc4 = r.pc + 32'd4;
    if (r.link) begin e.val = pc4; e.ovf = 1'b0; end
`ifndef EXEC_OVF_EN
    e.ovf = 1'b0;
`endif
    case (r.br)
      2'd1: tk = (r.s1 == r.s2);
      2'd2: tk = (r.s1 != r.s2);
      2'd3: tk = ($signed(r.s1) > 0);
      default: tk = 1'b0;
    endcase
    e.taken = 1'b1;
    if (r.jr)      e.npc = r.s1;
    else if (r.jp) e.npc = {pc4[31:28], r.idx, 2'b00};
    else if (tk)   e.npc = pc4 + {{14{r.im[15]}}, r.im, 2'b00};
    else begin     e.npc = pc4; e.taken = 1'b0; end
    return e;
  endfunction

  function automatic req_t mk(logic [3:0] op, logic [31:0] s1, logic [31:0] s2);
    req_t r;
    r.op = op; r.s1 = s1; r.s2 = s2; r.im = '0; r.use_im = 0; r.sign_x = 0; r.sa = '0;
    r.br = '0; r.jp = 0; r.jr = 0; r.link = 0; r.idx = '0; r.pc = 32'h0000_1000;
    return r;
  endfunction

  task automatic drive(input req_t r);
    alu_op = r.op; in_s1 = r.s1; in_s2 = r.s2; im = r.im; use_im = r.use_im;
    sign_x = r.sign_x; sa = r.sa; br_type = r.br; jp = r.jp; jr = r.jr; link = r.link;
    instr_idx = r.idx; pc = r.pc;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input req_t r, input bit push);
    bit acc = 1'b0;
    int n = 0;
    exp_t e;
    drive(r);
    in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      failures++;
      $display("FAIL accept_timeout: op %0d never accepted", r.op);
    end else if (push) begin
      e = model(r);
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin @(negedge clock); n++; end
    chk("drain_empty", 64'(sb.size()), 0);
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops the scoreboard on every handshake and checks hold-stability under stall.
  logic [65:0] held;
  bit          hold = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) hold = 1'b0;
    else begin
      if (hold) begin
        chk("hold_valid", 64'(out_valid), 1);
        chk("hold_data", 64'({out_val, out_pc, out_taken, out_ovf} != held), 0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL spurious_output: got val 0x%0h with nothing expected", out_val);
        end else begin
          e = sb.pop_front();
          chk("out_val", 64'(out_val), 64'(e.val));
          chk("out_pc", 64'(out_pc), 64'(e.npc));
          chk("out_taken", 64'(out_taken), 64'(e.taken));
          chk("out_ovf", 64'(out_ovf), 64'(e.ovf));
        end
      end
      hold = out_valid && !out_ready;
      held = {out_val, out_pc, out_taken, out_ovf};
    end
  end

  initial begin
    req_t r, r2;
    int n;
    bit seen;
    repeat (2) @(negedge clock);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_val", 64'(out_val), 0);
    chk("rst_pc", 64'(out_pc), 0);
    chk("rst_taken", 64'(out_taken), 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_in_ready", 64'(in_ready), 1);
    @(posedge clock);
    #1;

    r = mk(4'd0, 32'h7FFF_FFFF, 32'h1); r.pc = 32'h200;
    send(r, 1);
    @(negedge clock);
    chk("add_latency1", 64'(out_valid), 1);
    @(posedge clock);
    #1;

    r = mk(4'd0, 32'd5, 32'd5); r.pc = 32'h100; r.im = 16'hFFFE; r.br = 2'd1;
    send(r, 1);
    r.br = 2'd2;
    send(r, 1);

    send(mk(4'd11, 32'hFFFF_FFFF, 32'd2), 1);
    n = 0;
    while (n < 40) begin
      @(negedge clock);
      if (in_ready) break;
      n++;
    end
    chk("multu_busy_cycles", 64'(n), 32);
    chk("multu_latency", 64'(out_valid), 1);
    @(posedge clock);
    #1;
    send(mk(4'd13, 32'h0, 32'h0), 1);

    send(mk(4'd12, 32'd7, 32'd0), 1);
    send(mk(4'd13, 32'h0, 32'h0), 1);
    send(mk(4'd12, 32'd100, 32'd7), 1);
    send(mk(4'd13, 32'h0, 32'h0), 1);
    send(mk(4'd14, 32'h0, 32'h0), 1);
    drain();

    // Back-pressure: first result stalls 3 cycles while a second request waits.
    ready_force = 1'b0;
    @(posedge clock);
    #2;
    r = mk(4'd0, 32'd10, 32'd20);
    send(r, 1);
    r2 = mk(4'd1, 32'd3, 32'd9);
    drive(r2);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp_in_ready", 64'(in_ready), 0);
      chk("bp_val", 64'(out_val), 30);
    end
    ready_force = 1'b1;
    @(posedge clock);
    #1;
    send(r2, 1);
    drain();

    // Flush on the 10th cycle of a DIVU must not commit HI/LO (still 2/14).
    send(mk(4'd12, 32'hFFFF_FFFF, 32'd3), 0);
    repeat (9) @(posedge clock);
    #1 flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    @(negedge clock);
    chk("flush_in_ready", 64'(in_ready), 1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_output", 64'(seen), 0);
    @(posedge clock);
    #1;
    send(mk(4'd13, 32'h0, 32'h0), 1);
    send(mk(4'd14, 32'h0, 32'h0), 1);
    drain();

    // Asynchronous reset in the middle of a MULTU.
    send(mk(4'd11, 32'h1234, 32'h5678), 0);
    repeat (5) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_outputs", 64'({out_valid, out_val, out_pc, out_taken, out_ovf}), 0);
    hi_m = '0;
    lo_m = '0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    send(mk(4'd13, 32'h0, 32'h0), 1);
    send(mk(4'd14, 32'h0, 32'h0), 1);
    drain();

    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int k;
      k = $urandom_range(0, 99);
      r = mk(4'd0, rnd_val(), rnd_val());
      if (k < 7)       r.op = 4'd11;
      else if (k < 14) r.op = 4'd12;
      else begin
        r.op = 4'($urandom_range(0, 13));
        if (r.op > 4'd10) r.op = r.op + 4'd2;
        r.im = 16'($urandom); r.use_im = $urandom_range(0, 1) == 1;
        r.sign_x = $urandom_range(0, 1) == 1; r.sa = 5'($urandom);
        r.br = 2'($urandom); r.jp = $urandom_range(0, 9) == 0;
        r.jr = $urandom_range(0, 9) == 0; r.link = $urandom_range(0, 7) == 0;
        r.idx = 26'($urandom); r.pc = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 3) == 0) r.s2 = r.s1;
      end
      send(r, 1);
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1;
      end
    end
    rnd_ready = 1'b0;
    ready_force = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_pipe.md
Name: execute_pipe

Overview:
- Parametrised, registered successor to the single-cycle execute stage.
- Performs ALU ops, branch/jump target resolution and link values.
- Adds an iterative multi-cycle MULTU/DIVU unit with HI/LO registers.
- Sits between decode and memory stages; valid/ready handshakes on both sides give back-pressure and stall support.

Parameters:
DATA_W, 32, operand/result width (power of 2, >= 8)
PC_W, 32, program-counter width (>= 28)
SA_W, $clog2(DATA_W), shift-amount width

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill: aborts mul/div, drops output
in_valid  in  1  request valid
in_ready  out  1  stage accepts request this cycle
alu_op  in  4  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOR,6 SLT,7 SLTU,8 SLL,9 SRL,10 SRA,11 MULTU,12 DIVU,13 MFHI,14 MFLO,15 LUI
in_s1  in  DATA_W  operand A
in_s2  in  DATA_W  operand B
im  in  16  immediate
use_im  in  1  B = extended im
sign_x  in  1  im sign-extend (1) / zero-extend (0)
sa  in  SA_W  shift amount
br_type  in  2  0 none,1 BEQ,2 BNE,3 BGTZ
jp  in  1  J-type jump
jr  in  1  register jump (target = in_s1)
link  in  1  result = pc+4
instr_idx  in  26  jump index
pc  in  PC_W  instruction PC
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_val  out  DATA_W  result
out_pc  out  PC_W  next PC
out_taken  out  1  branch/jump redirect
out_ovf  out  1  signed overflow (see Optional Feature)

Behaviour:
- Reset (async, reset_n=0): out_valid=0, out_val=0, out_pc=0, out_taken=0, out_ovf=0, HI=LO=0, FSM=IDLE, count=0.
- FSM states: IDLE, MUL, DIV.
- in_ready = (FSM==IDLE) && (!out_valid || out_ready) && !flush.
- Accept = in_valid && in_ready.
- Single-cycle ops: output registers load on accept; out_valid=1 the next cycle (latency 1).
- Output holds stable while out_valid && !out_ready.
- out_valid clears on out_ready unless a new accept occurs in the same cycle (full throughput).
- Operand B = use_im ? ext(im) : in_s2.
- Shifts use sa; the instruction shifts operand B.
- LUI: {im, zeros} truncated/extended to DATA_W.
- SLT is signed; SLTU is unsigned; results are 0/1 zero-extended.
- ADD/SUB wrap modulo 2^DATA_W.
- Branch: compare in_s1 vs in_s2.
  - BEQ: equal. BNE: not equal. BGTZ: signed in_s1 > 0.
  - Taken: out_pc = pc+4+(sext(im)<<2), out_taken=1.
  - Not taken: out_pc = pc+4, out_taken=0.
- jp: out_pc = {pc4[PC_W-1:28], instr_idx, 2'b00}, out_taken=1.
- jr: out_pc = in_s1[PC_W-1:0], out_taken=1.
- Priority: jr > jp > branch > sequential.
- link: out_val = pc+4 (zero-extended), overrides ALU result.
- MULTU accept: FSM IDLE->MUL, shift-add over DATA_W cycles.
  - Then HI:LO = in_s1*in_s2 (2*DATA_W unsigned), out_val = LO, out_valid=1, FSM->IDLE.
  - Accept to out_valid = DATA_W+1 cycles.
- DIVU accept: same flow through DIV, restoring division.
  - LO = quotient, HI = remainder, out_val = LO.
  - Divide-by-zero: LO = all ones, HI = dividend, no exception.
- MFHI/MFLO: out_val = HI/LO as of end of the previous completed mul/div (latency 1). Issued during MUL/DIV they are simply not accepted (in_ready=0).
- flush: on flush=1 at the clock edge:
  - out_valid, out_taken cleared.
  - Any MUL/DIV aborts to IDLE; HI/LO are left unchanged (partial results are not committed).
  - A request presented that cycle is not accepted.
- reset_n asserted mid-MUL/DIV: immediate return to reset values.

Optional Feature:
- Macro EXEC_OVF_EN.
- Defined: ADD/SUB with signed overflow set out_ovf=1 alongside the (wrapped) result; out_ovf is registered with out_val and 0 for all other ops.
- Undefined: out_ovf tied to 0 and no overflow logic is synthesised.

Test Plan:
- DATA_W=32, ADD 0x7FFFFFFF+1, out_ready=1 -> next cycle out_val=0x80000000, out_valid=1; out_ovf=1 only with EXEC_OVF_EN.
- BEQ pc=0x100, in_s1=in_s2=5, im=0xFFFE -> out_pc=0xFC, out_taken=1. BNE with same operands -> out_pc=0x104, out_taken=0.
- MULTU 0xFFFFFFFF*2, then MFHI -> in_ready low 32 cycles; out_val=0xFFFFFFFE at cycle 33; MFHI returns 0x1.
- DIVU 7/0 -> LO=0xFFFFFFFF, HI=7; DIVU 100/7 -> LO=14, HI=2.
- Back-pressure: out_ready=0 for 3 cycles after ADD result, second request held -> out_val stable, in_ready=0; on out_ready=1 the second result follows next cycle, no loss or duplication.
- Flush at cycle 10 of DIVU -> out_valid stays 0, in_ready=1 next cycle, HI/LO unchanged. reset_n pulse mid-MULTU -> all outputs 0 asynchronously.
